// File: rtl/bcd_time_pkg.sv
// Shared BCD time-of-day layout (hh:mm:ss.mmm) for the countdown timer and stopwatch.
// Digit indices, per-digit limits, timer states and the preset clamp helper.
package bcd_time_pkg;

  localparam int DIG_W      = 4;
  localparam int NUM_DIGITS = 9;
  localparam int TIME_W     = DIG_W * NUM_DIGITS;

  localparam int DIG_MS1   = 0;
  localparam int DIG_MS10  = 1;
  localparam int DIG_MS100 = 2;
  localparam int DIG_S1    = 3;
  localparam int DIG_S10   = 4;
  localparam int DIG_M1    = 5;
  localparam int DIG_M10   = 6;
  localparam int DIG_H1    = 7;
  localparam int DIG_H10   = 8;

  localparam logic [DIG_W-1:0] MAX_DEC = 4'd9;
  localparam logic [DIG_W-1:0] MAX_SEX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

  function automatic logic [DIG_W-1:0] digit_max(input int idx);
    logic [DIG_W-1:0] m;
    if ((idx == DIG_S10) || (idx == DIG_M10)) begin
      m = MAX_SEX;
    end else begin
      m = MAX_DEC;
    end
    return m;
  endfunction

  // Out-of-range digits saturate at their limit instead of being rejected.
  function automatic logic [TIME_W-1:0] clamp_bcd(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] r;
    r = {TIME_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIG_W +: DIG_W] > digit_max(i)) begin
        r[i*DIG_W +: DIG_W] = digit_max(i);
      end else begin
        r[i*DIG_W +: DIG_W] = v[i*DIG_W +: DIG_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the timer and its controller.
interface countdown_timer_if;
  import bcd_time_pkg::*;

  logic              load;
  logic [TIME_W-1:0] load_val;
  logic              start;
  logic              stop;
  logic [TIME_W-1:0] out_o;
  logic              running_o;
  logic              done_o;
  logic              expired_o;

  modport master (
    output load, load_val, start, stop,
    input  out_o, running_o, done_o, expired_o
  );

  modport slave (
    input  load, load_val, start, stop,
    output out_o, running_o, done_o, expired_o
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a ripple-borrow decrementer; MAX is the value reloaded on borrow-through.
module bcd_digit_dec #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  // Decrement when borrowed from; a zero digit wraps to MAX and passes the borrow on.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
        borrow_out = 1'b0;
      end
    end else begin
      next_digit = digit;
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss.mmm countdown timer: load a preset, decrement once per ms while running,
// flag expiry at zero.
module countdown_timer
  import bcd_time_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic              clk_i,
  input  logic              resetn,
  countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  timer_state_e      state_r, state_nxt_s;
  logic [TIME_W-1:0] count_r, count_nxt_s, dec_val_s;
  logic [PW-1:0]     presc_r, presc_nxt_s;
  logic              running_r, done_r, expired_r;
  logic              running_nxt_s, done_nxt_s, expired_nxt_s;
  logic [NUM_DIGITS:0] borrow_s;
  logic              tick_s, underflow_s;

  assign borrow_s[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_dec #(
      .MAX (digit_max(g))
    ) u_dec (
      .digit      (count_r[g*DIG_W +: DIG_W]),
      .borrow_in  (borrow_s[g]),
      .next_digit (dec_val_s[g*DIG_W +: DIG_W]),
      .borrow_out (borrow_s[g+1])
    );
  end

  // A borrow out of the hours tens digit would mean counting below zero.
  assign underflow_s = borrow_s[NUM_DIGITS];
  assign tick_s      = (state_r == ST_RUN) && (presc_r == PRESC_LAST);

  // State, counter, prescaler and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      count_r   <= {TIME_W{1'b0}};
      presc_r   <= {PW{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      presc_r   <= presc_nxt_s;
      running_r <= running_nxt_s;
      done_r    <= done_nxt_s;
      expired_r <= expired_nxt_s;
    end
  end

  // Next state: load > stop > start > tick.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    presc_nxt_s = presc_r;
    if (bus.load) begin
      state_nxt_s = ST_IDLE;
      count_nxt_s = clamp_bcd(bus.load_val);
      presc_nxt_s = {PW{1'b0}};
    end else if (bus.stop && (state_r == ST_RUN)) begin
      state_nxt_s = ST_IDLE;
    end else if (bus.start && (state_r == ST_IDLE) && (count_r != {TIME_W{1'b0}})) begin
      state_nxt_s = ST_RUN;
      presc_nxt_s = {PW{1'b0}};
    end else if (state_r == ST_RUN) begin
      if (tick_s) begin
        presc_nxt_s = {PW{1'b0}};
        if ((dec_val_s == {TIME_W{1'b0}}) || underflow_s) begin
          state_nxt_s = ST_EXPIRED;
          count_nxt_s = {TIME_W{1'b0}};
        end else begin
          count_nxt_s = dec_val_s;
        end
      end else begin
        presc_nxt_s = presc_r + PW'(1);
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Status flags decoded from the upcoming state; done marks the RUN->EXPIRED edge.
  always_comb begin
    running_nxt_s = 1'b0;
    expired_nxt_s = 1'b0;
    done_nxt_s    = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        running_nxt_s = 1'b1;
      end
      ST_EXPIRED: begin
        expired_nxt_s = 1'b1;
        done_nxt_s    = (state_r == ST_RUN);
      end
      default: begin
        running_nxt_s = 1'b0;
        expired_nxt_s = 1'b0;
        done_nxt_s    = 1'b0;
      end
    endcase
  end

  assign bus.out_o     = count_r;
  assign bus.running_o = running_r;
  assign bus.done_o    = done_r;
  assign bus.expired_o = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, hand-written corner sequences and random
// stimulus against a millisecond-count reference model.
module tb_countdown_timer;

  localparam int TD = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic clk = 1'b0;
  logic resetn;
  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk_i  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int m_state = M_IDLE;
  int m_presc = 0;
  int m_ms    = 0;
  bit m_done  = 1'b0;

  typedef struct {
    bit          rn;
    bit          ld;
    logic [35:0] lv;
    bit          st;
    bit          sp;
    int          idle;
    logic [35:0] e_out;
    bit          e_run;
    bit          e_done;
    bit          e_exp;
    string       name;
  } vec_t;

  vec_t vecs[17];

  // Remaining time in plain milliseconds -> display BCD.
  function automatic logic [35:0] to_bcd(input int t);
    logic [35:0] r;
    int ms, s, m, h, st;
    ms = t % 1000;
    st = t / 1000;
    s  = st % 60;
    m  = (st / 60) % 60;
    h  = st / 3600;
    r = 36'd0;
    r[3:0]   = 4'(ms % 10);
    r[7:4]   = 4'((ms / 10) % 10);
    r[11:8]  = 4'(ms / 100);
    r[15:12] = 4'(s % 10);
    r[19:16] = 4'(s / 10);
    r[23:20] = 4'(m % 10);
    r[27:24] = 4'(m / 10);
    r[31:28] = 4'(h % 10);
    r[35:32] = 4'(h / 10);
    return r;
  endfunction

  // Preset -> milliseconds, saturating each digit at its limit.
  function automatic int preset_ms(input logic [35:0] v);
    int d[9];
    int lim;
    for (int i = 0; i < 9; i++) begin
      lim = (i == 4 || i == 6) ? 5 : 9;
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > lim) d[i] = lim;
    end
    return (((d[8]*10 + d[7]) * 3600 + (d[6]*10 + d[5]) * 60 + d[4]*10 + d[3]) * 1000)
           + d[2]*100 + d[1]*10 + d[0];
  endfunction

  task automatic model_edge(input bit rn, input bit ld, input logic [35:0] lv,
                            input bit st, input bit sp);
    if (!rn) begin
      m_state = M_IDLE; m_ms = 0; m_presc = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ld) begin
        m_ms = preset_ms(lv); m_state = M_IDLE; m_presc = 0;
      end else if (sp && m_state == M_RUN) begin
        m_state = M_IDLE;
      end else if (st && m_state == M_IDLE && m_ms != 0) begin
        m_state = M_RUN; m_presc = 0;
      end else if (m_state == M_RUN) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          m_ms = m_ms - 1;
          if (m_ms == 0) begin
            m_state = M_EXP; m_done = 1'b1;
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got out=%h run=%b done=%b exp=%b, want out=%h run=%b done=%b exp=%b",
               name, act[38:3], act[2], act[1], act[0], exp[38:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [38:0] dut_vec();
    return {bus.out_o, bus.running_o, bus.done_o, bus.expired_o};
  endfunction

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input bit rn, input bit ld, input logic [35:0] lv,
                      input bit st, input bit sp);
    resetn = rn; bus.load = ld; bus.load_val = lv; bus.start = st; bus.stop = sp;
    @(posedge clk);
    model_edge(rn, ld, lv, st, sp);
    @(negedge clk);
    check("model", dut_vec(), {to_bcd(m_ms), m_state == M_RUN, m_done, m_state == M_EXP});
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_now(input string name, input logic [35:0] o, input bit r,
                            input bit d, input bit e);
    check(name, dut_vec(), {o, r, d, e});
  endtask

  initial begin
    logic [63:0] rv;
    logic [35:0] lv;
    bit rn, ld, st, sp;

    resetn = 1'b0; bus.load = 1'b0; bus.load_val = 36'd0; bus.start = 1'b0; bus.stop = 1'b0;

    //           rn    ld    lv               st    sp    idle out              run   done  exp
    vecs[0]  = '{1'b0, 1'b0, 36'd0,           1'b0, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b0, "reset1"};
    vecs[1]  = '{1'b0, 1'b0, 36'd0,           1'b0, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b0, "reset2"};
    vecs[2]  = '{1'b1, 1'b1, 36'h000000005,   1'b0, 1'b0, 0, 36'h5,           1'b0, 1'b0, 1'b0, "load5"};
    vecs[3]  = '{1'b1, 1'b0, 36'd0,           1'b1, 1'b0, 0, 36'h5,           1'b1, 1'b0, 1'b0, "start5"};
    vecs[4]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 2, 36'h5,           1'b1, 1'b0, 1'b0, "no_early_tick"};
    vecs[5]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 0, 36'h4,           1'b1, 1'b0, 1'b0, "dec4"};
    vecs[6]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 3, 36'h3,           1'b1, 1'b0, 1'b0, "dec3"};
    vecs[7]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 3, 36'h2,           1'b1, 1'b0, 1'b0, "dec2"};
    vecs[8]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 3, 36'h1,           1'b1, 1'b0, 1'b0, "dec1"};
    vecs[9]  = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 2, 36'h1,           1'b1, 1'b0, 1'b0, "hold1"};
    vecs[10] = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 0, 36'h0,           1'b0, 1'b1, 1'b1, "reach_zero"};
    vecs[11] = '{1'b1, 1'b0, 36'd0,           1'b0, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b1, "done_one_cycle"};
    vecs[12] = '{1'b1, 1'b0, 36'd0,           1'b1, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b1, "start_in_expired"};
    vecs[13] = '{1'b1, 1'b1, 36'h000000002,   1'b0, 1'b0, 0, 36'h2,           1'b0, 1'b0, 1'b0, "load_leaves_expired"};
    vecs[14] = '{1'b1, 1'b1, 36'h000000000,   1'b0, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b0, "load_zero"};
    vecs[15] = '{1'b1, 1'b0, 36'd0,           1'b1, 1'b0, 0, 36'h0,           1'b0, 1'b0, 1'b0, "start_at_zero"};
    vecs[16] = '{1'b1, 1'b1, 36'h0000F00F3,   1'b0, 1'b0, 0, 36'h000050093,   1'b0, 1'b0, 1'b0, "clamp"};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rn, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp);
      nop(vecs[i].idle);
      expect_now(vecs[i].name, vecs[i].e_out, vecs[i].e_run, vecs[i].e_done, vecs[i].e_exp);
    end

    // One minute: first tick borrows through every lower digit.
    step(1'b1, 1'b1, 36'h000100000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 36'd0, 1'b1, 1'b0);
    nop(4);
    expect_now("min_borrow", 36'h000059999, 1'b1, 1'b0, 1'b0);
    nop(4);
    expect_now("min_next", 36'h000059998, 1'b1, 1'b0, 1'b0);

    // Stop landing on the tick edge suppresses that decrement; resume restarts the prescaler.
    step(1'b1, 1'b1, 36'h000000009, 1'b0, 1'b0);
    step(1'b1, 1'b0, 36'd0, 1'b1, 1'b0);
    nop(3);
    step(1'b1, 1'b0, 36'd0, 1'b0, 1'b1);
    expect_now("stop_on_tick", 36'h9, 1'b0, 1'b0, 1'b0);
    nop(2);
    expect_now("paused", 36'h9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 36'd0, 1'b1, 1'b0);
    nop(3);
    expect_now("resume_no_early", 36'h9, 1'b1, 1'b0, 1'b0);
    nop(1);
    expect_now("resume_dec", 36'h8, 1'b1, 1'b0, 1'b0);

    // Reset mid-run.
    step(1'b1, 1'b1, 36'h000000050, 1'b0, 1'b0);
    step(1'b1, 1'b0, 36'd0, 1'b1, 1'b0);
    nop(3);
    step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
    expect_now("reset_mid_run", 36'h0, 1'b0, 1'b0, 1'b0);
    nop(1);
    expect_now("after_reset", 36'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rv = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) lv = {28'd0, rv[7:0]};
      else                           lv = rv[35:0];
      rn = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 29) == 0);
      step(rn, ld, lv, st, sp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
